// File: rtl/press_button_bank.sv
// Bank of N independent button-to-pulse channels: sync, edge detect, fixed pulse, lockout.
// Optional hold-repeat behaviour is enabled by defining PRESS_BUTTON_AUTOREPEAT_EN.
module press_button_bank #(
  parameter int unsigned N        = 4,
  parameter logic [31:0] T_HIGH   = 32'd2,
  parameter logic [31:0] T_LOW    = 32'd50000000,
  parameter logic [31:0] T_REPEAT = 32'd25000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button,
  output logic [N-1:0] signal,
  output logic [N-1:0] busy,
  output logic         any
);

`ifdef PRESS_BUTTON_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPulse   = 2'd1,
    StLockout = 2'd2,
    StHold    = 2'd3
  } state_e;
`else
  // Encoding 2'd3 is unreachable here and is recovered by the default arm.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPulse   = 2'd1,
    StLockout = 2'd2
  } state_e;

  logic w_unused_t_repeat;
  assign w_unused_t_repeat = ^T_REPEAT;
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic        r_s1;
    logic        r_s2;
    logic        r_prev;
    logic        w_rise;
    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_d;

    assign w_rise = r_s2 & ~r_prev;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_prev  <= 1'b0;
        r_state <= StIdle;
        r_cnt   <= 32'd0;
      end else begin
        r_s1    <= button[g];
        r_s2    <= r_s1;
        r_prev  <= r_s2;
        r_state <= w_state_d;
        r_cnt   <= w_cnt_d;
      end
    end

    always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      case (r_state)
        StIdle: begin
          if (w_rise) begin
            w_state_d = StPulse;
            w_cnt_d   = 32'd0;
          end
        end
        StPulse: begin
          if (r_cnt == T_HIGH - 32'd1) begin
            w_state_d = StLockout;
            w_cnt_d   = 32'd0;
          end else begin
            w_cnt_d = r_cnt + 32'd1;
          end
        end
        StLockout: begin
          if (r_cnt == T_LOW - 32'd1) begin
`ifdef PRESS_BUTTON_AUTOREPEAT_EN
            w_state_d = r_s2 ? StHold : StIdle;
`else
            w_state_d = StIdle;
`endif
            w_cnt_d   = 32'd0;
          end else begin
            w_cnt_d = r_cnt + 32'd1;
          end
        end
`ifdef PRESS_BUTTON_AUTOREPEAT_EN
        StHold: begin
          // Release wins over the repeat timer.
          if (!r_s2) begin
            w_state_d = StIdle;
            w_cnt_d   = 32'd0;
          end else if (r_cnt == T_REPEAT - 32'd1) begin
            w_state_d = StPulse;
            w_cnt_d   = 32'd0;
          end else begin
            w_cnt_d = r_cnt + 32'd1;
          end
        end
`endif
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = 32'd0;
        end
      endcase
    end

    assign signal[g] = (r_state == StPulse);
    assign busy[g]   = (r_state != StIdle);
  end

  assign any = |signal;

endmodule

// File: tb/tb_press_button_bank.sv
// Directed bench for press_button_bank with N=4, T_HIGH=2, T_LOW=10, T_REPEAT=5.
// Expectations follow PRESS_BUTTON_AUTOREPEAT_EN when the macro is defined.
module tb_press_button_bank;

  logic       clk;
  logic       rst;
  logic [3:0] button;
  logic [3:0] signal;
  logic [3:0] busy;
  logic       any;

  int vectors;
  int miscompares;

  press_button_bank #(
    .N        (4),
    .T_HIGH   (32'd2),
    .T_LOW    (32'd10),
    .T_REPEAT (32'd5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .signal (signal),
    .busy   (busy),
    .any    (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       e_sig;
    logic       e_busy;
    logic [3:0] e_vec;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    button      = 4'b0000;

    // Reset is asynchronous: outputs are quiet before any clock edge.
    #1;
    check("rst_signal", 32'(signal), 32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_any",    32'(any),    32'h0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Single press on channel 0, held for three samples.
    button = 4'b0001;
    for (int j = 0; j < 16; j++) begin
      tick();
      e_sig  = (j == 2 || j == 3);
      e_busy = (j >= 2 && j <= 13);
      check($sformatf("a_sig[%0d]", j),  32'(signal), 32'({3'b000, e_sig}));
      check($sformatf("a_busy[%0d]", j), 32'(busy),   32'({3'b000, e_busy}));
      check($sformatf("a_any[%0d]", j),  32'(any),    32'(e_sig));
      if (j == 2) button = 4'b0000;
    end
    tick(); tick();

    // Glitching channel 1: one pulse only, lockout swallows the rest.
    for (int j = 0; j < 18; j++) begin
      button[1] = (j < 8) ? ~j[0] : 1'b0;
      tick();
      e_sig  = (j == 2 || j == 3);
      e_busy = (j >= 2 && j <= 13);
      check($sformatf("b_sig[%0d]", j),  32'(signal), 32'({2'b00, e_sig, 1'b0}));
      check($sformatf("b_busy[%0d]", j), 32'(busy),   32'({2'b00, e_busy, 1'b0}));
    end

    // All four channels rise together.
    button = 4'b1111;
    for (int j = 0; j < 16; j++) begin
      tick();
      e_vec = (j == 2 || j == 3) ? 4'b1111 : 4'b0000;
      check($sformatf("c_sig[%0d]", j),  32'(signal), 32'(e_vec));
      e_vec = (j >= 2 && j <= 13) ? 4'b1111 : 4'b0000;
      check($sformatf("c_busy[%0d]", j), 32'(busy),   32'(e_vec));
      check($sformatf("c_any[%0d]", j),  32'(any),    32'((j == 2 || j == 3) ? 1 : 0));
      if (j == 2) button = 4'b0000;
    end
    tick(); tick();

    // Channel 2 held for 60 samples.
    button = 4'b0100;
    for (int j = 0; j < 70; j++) begin
      tick();
`ifdef PRESS_BUTTON_AUTOREPEAT_EN
      e_busy = (j >= 2 && j <= 64);
      e_sig  = e_busy && (((j - 2) % 17) < 2);
`else
      e_busy = (j >= 2 && j <= 13);
      e_sig  = (j == 2 || j == 3);
`endif
      check($sformatf("d_sig[%0d]", j),  32'(signal), 32'({1'b0, e_sig, 2'b00}));
      check($sformatf("d_busy[%0d]", j), 32'(busy),   32'({1'b0, e_busy, 2'b00}));
      if (j == 59) button = 4'b0000;
    end
    tick(); tick();

    // Reset asserted mid-pulse on channel 0, button kept held through release.
    button = 4'b0001;
    tick(); tick(); tick();
    check("e_pre_sig", 32'(signal), 32'h1);
    rst = 1'b1;
    #1;
    check("e_rst_sig",  32'(signal), 32'h0);
    check("e_rst_busy", 32'(busy),   32'h0);
    check("e_rst_any",  32'(any),    32'h0);
    tick(); tick();
    check("e_rst_hold", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      e_sig  = (j == 2 || j == 3);
      e_busy = (j >= 2 && j <= 13);
      check($sformatf("e_sig[%0d]", j),  32'(signal), 32'({3'b000, e_sig}));
      check($sformatf("e_busy[%0d]", j), 32'(busy),   32'({3'b000, e_busy}));
      if (j == 3) button = 4'b0000;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/press_button_bank.md
PRESS_BUTTON_BANK -- requirements
Module: press_button_bank

Interface
REQ-001 SHALL have parameter N, default 4: number of independent button channels, 1..32.
REQ-002 SHALL have parameter T_HIGH, default 32'd2: output pulse length in clk cycles, 1 or more.
REQ-003 SHALL have parameter T_LOW, default 32'd50000000: lockout length in clk cycles after each pulse, 1 or more.
REQ-004 SHALL have parameter T_REPEAT, default 32'd25000000: hold-repeat interval in clk cycles, 1 or more; used only when PRESS_BUTTON_AUTOREPEAT_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge only.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port button, input, N bits: raw, asynchronous, active-high push buttons.
REQ-008 SHALL have port signal, output, N bits: one-shot pulse per channel, active-high.
REQ-009 SHALL have port busy, output, N bits: 1 while the channel is in any state other than IDLE.
REQ-010 SHALL have port any, output, 1 bit: OR of all signal bits.

Function
REQ-011 SHALL give each channel a 2-flop synchronizer (s1 then s2), a prev register holding the previous s2, one FSM and one 32-bit counter, with no sharing between channels.
REQ-012 SHALL implement per-channel FSM states IDLE, PULSE, LOCKOUT, plus HOLD when PRESS_BUTTON_AUTOREPEAT_EN is defined.
REQ-013 IDLE SHALL go to PULSE with the counter cleared when s2=1 and prev=0 (rising edge); a level that stays high SHALL NOT trigger.
REQ-014 Latency: when button is first sampled high at posedge k, the state SHALL be PULSE from posedge k+2.
REQ-015 PULSE SHALL last exactly T_HIGH cycles, then go to LOCKOUT with the counter cleared; releasing the button during PULSE SHALL NOT shorten the pulse.
REQ-016 LOCKOUT SHALL last exactly T_LOW cycles and ignore all button activity; where it exits to is set by REQ-025 and REQ-026.
REQ-017 signal[i] SHALL be decoded combinationally from the state register (state==PULSE), with no extra output register.
REQ-018 busy[i] SHALL be decoded the same way (state!=IDLE).
REQ-019 Counters SHALL be 32-bit and count up until count==T-1, then transition; counters SHALL never wrap.
REQ-020 Rising edges on several channels in the same cycle SHALL each produce a pulse on those channels in that same cycle.
REQ-021 An unreachable state encoding SHALL return to IDLE on the next posedge with the counter cleared.

Reset
REQ-022 On rst=1, with no clock needed: all FSMs SHALL be IDLE, counters 0, s1/s2/prev 0, signal=0, busy=0, any=0.
REQ-023 Reset asserted mid-PULSE SHALL drop signal the moment reset is asserted; no pulse SHALL resume after release.
REQ-024 After reset releases, a button already held high SHALL produce one pulse, because prev=0 makes it a rising edge.

Configuration
REQ-025 Macro PRESS_BUTTON_AUTOREPEAT_EN undefined: LOCKOUT end SHALL go to IDLE; a held button produces exactly one pulse, and a new pulse needs a release then a new press.
REQ-026 Macro PRESS_BUTTON_AUTOREPEAT_EN defined: LOCKOUT end with s2=1 SHALL go to HOLD, else to IDLE.
REQ-027 HOLD SHALL count T_REPEAT cycles, then go to PULSE; s2=0 at any cycle in HOLD SHALL go to IDLE at once.
REQ-028 With the macro defined, a held button SHALL repeat pulses every T_HIGH+T_LOW+T_REPEAT cycles.

Verification
Bench parameters: N=4, T_HIGH=2, T_LOW=10, T_REPEAT=5.
REQ-029 button[0] rises at posedge 100 and is held 3 cycles -> signal[0]=1 at posedges 102-103, busy[0]=1 at 102-113, any mirrors signal[0].
REQ-030 button[1] glitches 0/1 every cycle for 8 cycles starting at posedge 200 -> exactly one 2-cycle pulse on signal[1], no second pulse before busy[1] falls.
REQ-031 button[3:0]=4'b1111 at posedge 300 -> signal=4'b1111 at posedges 302-303, all channels independent.
REQ-032 button[2] held 60 cycles, macro undefined -> exactly 1 pulse; macro defined -> pulses start at posedges k+2, k+19, k+36, k+53.
REQ-033 rst pulsed high during signal[0]=1 -> signal, busy and any go to 0 at once; with button held after release, one pulse starts 2 cycles later.
